// File: rtl/tow_pkg.sv
// Shared types and constants for the tug-of-war rope controller.
// Optional build macro used by this slice: TOW_WIN_BLINK_EN (blinking winner LED).
package tow_pkg;

    // Match controller states
    typedef enum logic [1:0] {
        PLAY  = 2'd0,
        HOLD  = 2'd1,
        WIN_R = 2'd2,
        WIN_L = 2'd3
    } state_t;

    // Default configuration
    localparam int TOW_HALF_LEN = 3;
    localparam int TOW_CLR_HOLD = 4;
    localparam int TOW_BLINK_W  = 24;

    // LED bar width: centre plus half_len steps each side
    function automatic int led_width(input int half_len);
        return 2 * half_len + 1;
    endfunction

    // Signed position width able to hold [-half_len, +half_len]
    function automatic int pos_width(input int half_len);
        return $clog2(half_len + 1) + 1;
    endfunction

endpackage

// File: rtl/tow_led_decode.sv
// Signed rope position to one-hot LED bar, with an optional blink gate in win states.
// Build macro: TOW_WIN_BLINK_EN gates the bar with i_blink while i_win is high.
module tow_led_decode
    import tow_pkg::*;
#(
    parameter int HALF_LEN = TOW_HALF_LEN,
    parameter int PW       = pos_width(TOW_HALF_LEN),
    parameter int LED_W    = led_width(TOW_HALF_LEN)
) (
    input  logic signed [PW-1:0]    i_pos,
    input  logic                    i_win,
    input  logic                    i_blink,
    output logic        [LED_W-1:0] o_led
);

    logic [LED_W-1:0] w_onehot;

    // Bit (pos + HALF_LEN) lights; bit HALF_LEN is the centre, MSB the right end
    always_comb begin
        w_onehot = '0;
        for (int i = 0; i < LED_W; i++) begin
            if (int'(i_pos) == i - HALF_LEN) begin
                w_onehot[i] = 1'b1;
            end
        end
    end

`ifdef TOW_WIN_BLINK_EN
    assign o_led = i_win ? (w_onehot & {LED_W{i_blink}}) : w_onehot;
`else
    logic w_unused_blink;
    assign w_unused_blink = i_win ^ i_blink;
    assign o_led = w_onehot;
`endif

endmodule

// File: rtl/tow_rope_ctrl.sv
// Tug-of-war rope controller: consumes round results, moves the mark,
// re-arms the buttons via clr and declares the match winner.
// Build macro: TOW_WIN_BLINK_EN adds a free-running blink counter for the winner LED.
// Handshake: winrnd is a one-cycle strobe with right/tie qualified by it; it is
// only acted on in PLAY, never queued, and clr stays high whenever the controller
// is not ready (HOLD or a win state).
module tow_rope_ctrl
    import tow_pkg::*;
#(
    parameter int HALF_LEN = TOW_HALF_LEN,
    parameter int CLR_HOLD = TOW_CLR_HOLD,
    parameter int BLINK_W  = TOW_BLINK_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    winrnd,
    input  logic                    right,
    input  logic                    tie,
    output logic                    clr,
    output logic [2*HALF_LEN:0]     pos_led,
    output logic                    game_over,
    output logic                    win_right,
    output logic                    win_left,
    output state_t                  dbg_state
);

    localparam int PW    = pos_width(HALF_LEN);
    localparam int LED_W = led_width(HALF_LEN);
    localparam int CW    = (CLR_HOLD > 1) ? $clog2(CLR_HOLD) : 1;

    localparam logic signed [PW-1:0] POS_MAX = PW'(HALF_LEN);
    localparam logic signed [PW-1:0] POS_MIN = -POS_MAX;
    localparam logic signed [PW-1:0] POS_ONE = PW'(1);
    localparam logic [LED_W-1:0]     LED_CTR = LED_W'(1) << HALF_LEN;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic signed [PW-1:0]    r_pos;
    logic signed [PW-1:0]    w_pos_nxt;
    logic        [CW-1:0]    r_cnt;
    logic        [CW-1:0]    w_cnt_nxt;
    logic                    r_clr;
    logic                    r_game_over;
    logic                    r_win_right;
    logic                    r_win_left;
    logic        [LED_W-1:0] r_pos_led;
    logic        [LED_W-1:0] w_led_nxt;
    logic                    w_win_nxt;
    logic                    w_blink;

`ifdef TOW_WIN_BLINK_EN
    logic [BLINK_W-1:0] r_blink;

    // Free-running blink divider; MSB gates the winner LED
    always_ff @(posedge clk) begin
        if (rst) begin
            r_blink <= '0;
        end else begin
            r_blink <= r_blink + BLINK_W'(1);
        end
    end

    assign w_blink = r_blink[BLINK_W-1];
`else
    logic [BLINK_W-1:0] w_unused_blink_cnt;
    assign w_unused_blink_cnt = '0;
    assign w_blink = 1'b0;
`endif

    // Next state, next position and clr hold counter
    always_comb begin
        w_state_nxt = r_state;
        w_pos_nxt   = r_pos;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            PLAY: begin
                if (winrnd) begin
                    if (tie) begin
                        w_pos_nxt = r_pos;
                    end else if (right) begin
                        w_pos_nxt = r_pos + POS_ONE;
                    end else begin
                        w_pos_nxt = r_pos - POS_ONE;
                    end
                    w_cnt_nxt = CW'(CLR_HOLD - 1);
                    if (w_pos_nxt == POS_MAX) begin
                        w_state_nxt = WIN_R;
                    end else if (w_pos_nxt == POS_MIN) begin
                        w_state_nxt = WIN_L;
                    end else begin
                        w_state_nxt = HOLD;
                    end
                end
            end
            HOLD: begin
                if (r_cnt == '0) begin
                    w_state_nxt = PLAY;
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            WIN_R, WIN_L: begin
                w_state_nxt = r_state;
            end
            default: begin
                w_state_nxt = PLAY;
            end
        endcase
    end

    assign w_win_nxt = (w_state_nxt == WIN_R) || (w_state_nxt == WIN_L);

    tow_led_decode #(
        .HALF_LEN (HALF_LEN),
        .PW       (PW),
        .LED_W    (LED_W)
    ) u_led_decode (
        .i_pos   (w_pos_nxt),
        .i_win   (w_win_nxt),
        .i_blink (w_blink),
        .o_led   (w_led_nxt)
    );

    // State and registered outputs, all derived from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= PLAY;
            r_pos       <= '0;
            r_cnt       <= '0;
            r_clr       <= 1'b0;
            r_game_over <= 1'b0;
            r_win_right <= 1'b0;
            r_win_left  <= 1'b0;
            r_pos_led   <= LED_CTR;
        end else begin
            r_state     <= w_state_nxt;
            r_pos       <= w_pos_nxt;
            r_cnt       <= w_cnt_nxt;
            r_clr       <= (w_state_nxt != PLAY);
            r_game_over <= w_win_nxt;
            r_win_right <= (w_state_nxt == WIN_R);
            r_win_left  <= (w_state_nxt == WIN_L);
            r_pos_led   <= w_led_nxt;
        end
    end

    assign clr       = r_clr;
    assign pos_led   = r_pos_led;
    assign game_over = r_game_over;
    assign win_right = r_win_right;
    assign win_left  = r_win_left;
    assign dbg_state = r_state;

endmodule
